// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous-read font ROM among NUM_REQ text
// overlay requesters by fixed priority (index 0 highest). The winner's bit
// column and colours travel alongside the ROM read, so text_on/text_rgb are
// registered exactly 3 clocks after the request, at one pixel per clock.
// The enable mask is shadow-loaded on refresh_tick (frame boundary).
// Optional: define FONT_ARB_CONFLICT_CNT_EN to count per-frame overlap cycles
// on conflict_cnt; otherwise conflict_cnt is tied to zero.
module font_rom_arbiter #(
  parameter int                 NUM_REQ    = 4,
  parameter logic [NUM_REQ-1:0] RESET_MASK = {NUM_REQ{1'b1}},
  localparam int                GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  refresh_tick,
  input  logic [NUM_REQ-1:0]    en_mask_in,
  input  logic [NUM_REQ-1:0]    req_on,
  input  logic [NUM_REQ*11-1:0] req_rom_addr,
  input  logic [NUM_REQ*3-1:0]  req_bit_addr,
  input  logic [NUM_REQ*12-1:0] req_fg_rgb,
  input  logic [NUM_REQ*12-1:0] req_bg_rgb,
  input  logic [NUM_REQ-1:0]    req_solid,
  output logic [10:0]           rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  text_on,
  output logic [11:0]           text_rgb,
  output logic [GW-1:0]         grant_idx,
  output logic [15:0]           conflict_cnt
);

  logic [NUM_REQ-1:0] mask_q;
  logic [NUM_REQ-1:0] act;
  logic               v;
  logic [GW-1:0]      g;
  logic [10:0]        s_addr;
  logic [2:0]         s_bit;
  logic [11:0]        s_fg;
  logic [11:0]        s_bg;
  logic               s_solid;

  logic               v1, v2;
  logic [GW-1:0]      g1, g2;
  logic [2:0]         bit1, bit2;
  logic [11:0]        fg1, fg2, bg1, bg2;
  logic               solid1, solid2;
  logic               fb;

  // Enable mask shadow register; the tick cycle still arbitrates with the old mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mask_q <= RESET_MASK;
    else if (refresh_tick) mask_q <= en_mask_in;
  end

  // Fixed-priority arbitration: lowest active index wins and its fields are selected.
  always_comb begin
    act     = req_on & mask_q;
    v       = 1'b0;
    g       = '0;
    s_addr  = '0;
    s_bit   = '0;
    s_fg    = '0;
    s_bg    = '0;
    s_solid = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (act[i] && !v) begin
        v       = 1'b1;
        g       = GW'(i);
        s_addr  = req_rom_addr[11*i +: 11];
        s_bit   = req_bit_addr[3*i +: 3];
        s_fg    = req_fg_rgb[12*i +: 12];
        s_bg    = req_bg_rgb[12*i +: 12];
        s_solid = req_solid[i];
      end
    end
  end

  // Stage 1: register the ROM address (held while idle) and the winner's metadata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr <= '0;
      v1       <= 1'b0;
      g1       <= '0;
      bit1     <= '0;
      fg1      <= '0;
      bg1      <= '0;
      solid1   <= 1'b0;
    end else begin
      if (v) rom_addr <= s_addr;
      v1     <= v;
      g1     <= g;
      bit1   <= s_bit;
      fg1    <= s_fg;
      bg1    <= s_bg;
      solid1 <= s_solid;
    end
  end

  // Stage 2: metadata waits here while the ROM performs its read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2     <= 1'b0;
      g2     <= '0;
      bit2   <= '0;
      fg2    <= '0;
      bg2    <= '0;
      solid2 <= 1'b0;
    end else begin
      v2     <= v1;
      g2     <= g1;
      bit2   <= bit1;
      fg2    <= fg1;
      bg2    <= bg1;
      solid2 <= solid1;
    end
  end

  // Bit column 0 is the leftmost pixel, i.e. the MSB of the font word.
  assign fb = rom_data[3'd7 - bit2];

  // Stage 3: pick foreground, box background or transparent for this pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      text_on   <= 1'b0;
      text_rgb  <= '0;
      grant_idx <= '0;
    end else begin
      text_on   <= v2 & (solid2 | fb);
      text_rgb  <= !v2 ? 12'h000 : fb ? fg2 : solid2 ? bg2 : 12'h000;
      grant_idx <= v2 ? g2 : '0;
    end
  end

`ifdef FONT_ARB_CONFLICT_CNT_EN
  logic        multi;
  logic [15:0] run_q;
  logic [15:0] cnt_q;

  // Two or more active bits: clearing the lowest set bit leaves something.
  assign multi = |(act & (act - NUM_REQ'(1)));

  // Per-frame overlap counter; a tick publishes the run total before that
  // cycle's increment and restarts the run with the tick cycle's own overlap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= '0;
      cnt_q <= '0;
    end else if (refresh_tick) begin
      cnt_q <= run_q;
      run_q <= multi ? 16'd1 : 16'd0;
    end else if (multi && run_q != 16'hFFFF) begin
      run_q <= run_q + 16'd1;
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Self-checking bench for font_rom_arbiter: directed scenarios plus random
// traffic, scored against a per-cycle reference model with a 3-deep delay line.
module tb_font_rom_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          refresh_tick = 1'b0;
  logic [N-1:0]  en_mask_in = '1;
  logic [N-1:0]  req_on = '0;
  logic [N*11-1:0] req_rom_addr = '0;
  logic [N*3-1:0]  req_bit_addr = '0;
  logic [N*12-1:0] req_fg_rgb = '0;
  logic [N*12-1:0] req_bg_rgb = '0;
  logic [N-1:0]  req_solid = '0;
  logic [10:0]   rom_addr;
  logic [7:0]    rom_data = '0;
  logic          text_on;
  logic [11:0]   text_rgb;
  logic [1:0]    grant_idx;
  logic [15:0]   conflict_cnt;

  logic [7:0]    mem [2048];

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [N-1:0]  m_mask;
  logic          dl_on  [3];
  logic [11:0]   dl_rgb [3];
  logic [1:0]    dl_g   [3];
  logic [10:0]   m_addr;
  int unsigned   m_run;
  logic [15:0]   m_cc;

  font_rom_arbiter #(.NUM_REQ(N), .RESET_MASK(4'b1111)) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .en_mask_in(en_mask_in),
    .req_on(req_on), .req_rom_addr(req_rom_addr), .req_bit_addr(req_bit_addr),
    .req_fg_rgb(req_fg_rgb), .req_bg_rgb(req_bg_rgb), .req_solid(req_solid),
    .rom_addr(rom_addr), .rom_data(rom_data), .text_on(text_on), .text_rgb(text_rgb),
    .grant_idx(grant_idx), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // synchronous-read font ROM
  always @(posedge clk) rom_data <= mem[rom_addr];

  task automatic model_reset();
    m_mask = '1;
    for (int i = 0; i < 3; i++) begin
      dl_on[i] = 1'b0; dl_rgb[i] = '0; dl_g[i] = '0;
    end
    m_addr = '0; m_run = 0; m_cc = '0;
  endtask

  task automatic clear_reqs();
    req_on = '0; req_rom_addr = '0; req_bit_addr = '0;
    req_fg_rgb = '0; req_bg_rgb = '0; req_solid = '0;
    refresh_tick = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [10:0] a, input logic [2:0] b,
                         input logic [11:0] fg, input logic [11:0] bg, input logic s);
    req_rom_addr[11*i +: 11] = a;
    req_bit_addr[3*i +: 3]   = b;
    req_fg_rgb[12*i +: 12]   = fg;
    req_bg_rgb[12*i +: 12]   = bg;
    req_solid[i]             = s;
  endtask

  // One clock: predict from current inputs, advance, then score all outputs.
  task automatic cycle();
    logic [N-1:0] act;
    int           w;
    logic         on, fb, conf;
    logic [11:0]  rgb;
    logic [7:0]   word;
    logic [2:0]   b;
    act = req_on & m_mask;
    w = -1;
    for (int i = N - 1; i >= 0; i--) if (act[i]) w = i;
    on = 1'b0; rgb = '0;
    if (w >= 0) begin
      m_addr = req_rom_addr[11*w +: 11];
      word = mem[m_addr];
      b = req_bit_addr[3*w +: 3];
      fb = word[7 - int'(b)];
      on = fb | req_solid[w];
      rgb = fb ? req_fg_rgb[12*w +: 12] : (req_solid[w] ? req_bg_rgb[12*w +: 12] : 12'h000);
    end
    conf = ($countones(act) >= 2);
`ifdef FONT_ARB_CONFLICT_CNT_EN
    if (refresh_tick) begin
      m_cc = 16'(m_run);
      m_run = conf ? 1 : 0;
    end else if (conf && m_run < 65535) begin
      m_run++;
    end
`endif
    if (refresh_tick) m_mask = en_mask_in;
    @(posedge clk); #1;
    dl_on[2] = dl_on[1];  dl_rgb[2] = dl_rgb[1];  dl_g[2] = dl_g[1];
    dl_on[1] = dl_on[0];  dl_rgb[1] = dl_rgb[0];  dl_g[1] = dl_g[0];
    dl_on[0] = on;        dl_rgb[0] = rgb;        dl_g[0] = (w >= 0) ? 2'(w) : 2'd0;
    checks += 4;
    if (text_on !== dl_on[2]) begin
      errors++; $display("FAIL text_on @%0t: got %0b expected %0b", $time, text_on, dl_on[2]);
    end
    if (text_rgb !== dl_rgb[2]) begin
      errors++; $display("FAIL text_rgb @%0t: got %h expected %h", $time, text_rgb, dl_rgb[2]);
    end
    if (grant_idx !== dl_g[2]) begin
      errors++; $display("FAIL grant_idx @%0t: got %0d expected %0d", $time, grant_idx, dl_g[2]);
    end
    if (rom_addr !== m_addr) begin
      errors++; $display("FAIL rom_addr @%0t: got %h expected %h", $time, rom_addr, m_addr);
    end
    checks++;
    if (conflict_cnt !== m_cc) begin
      errors++; $display("FAIL conflict_cnt @%0t: got %0d expected %0d", $time, conflict_cnt, m_cc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_reqs();
    model_reset();
    #2;
    checks++;
    if ({text_on, text_rgb, grant_idx, rom_addr, conflict_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state: got on=%0b rgb=%h g=%0d addr=%h cc=%0d expected all zero",
               text_on, text_rgb, grant_idx, rom_addr, conflict_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
  endtask

  task automatic test_single();
    clear_reqs();
    mem[11'h241] = 8'h80;
    set_req(1, 11'h241, 3'd0, 12'h0f0, 12'h000, 1'b0);
    req_on = 4'b0010;
    cycle();
    checks++;
    if (rom_addr !== 11'h241) begin
      errors++; $display("FAIL single_rom_addr: got %h expected 241", rom_addr);
    end
    req_on = '0;
    cycle(); cycle();
    checks++;
    if (text_on !== 1'b1 || text_rgb !== 12'h0f0 || grant_idx !== 2'd1) begin
      errors++;
      $display("FAIL single_out: got on=%0b rgb=%h g=%0d expected on=1 rgb=0f0 g=1",
               text_on, text_rgb, grant_idx);
    end
    repeat (3) cycle();
  endtask

  task automatic test_solid();
    clear_reqs();
    mem[11'h300] = 8'h00;
    mem[11'h555] = 8'hFF;
    set_req(0, 11'h300, 3'd3, 12'h001, 12'h797, 1'b1);
    set_req(1, 11'h555, 3'd0, 12'hABC, 12'h000, 1'b0);
    req_on = 4'b0011;
    cycle();
    checks++;
    if (rom_addr !== 11'h300) begin
      errors++; $display("FAIL solid_rom_addr: got %h expected 300", rom_addr);
    end
    cycle(); cycle();
    checks++;
    if (text_on !== 1'b1 || text_rgb !== 12'h797 || grant_idx !== 2'd0) begin
      errors++;
      $display("FAIL solid_bg: got on=%0b rgb=%h g=%0d expected on=1 rgb=797 g=0",
               text_on, text_rgb, grant_idx);
    end
    req_on = '0;
    repeat (3) cycle();
    mem[11'h300] = 8'h10;
    req_on = 4'b0011;
    cycle(); cycle(); cycle();
    checks++;
    if (text_on !== 1'b1 || text_rgb !== 12'h001) begin
      errors++; $display("FAIL solid_fg: got on=%0b rgb=%h expected on=1 rgb=001", text_on, text_rgb);
    end
    req_on = '0;
    repeat (3) cycle();
  endtask

  task automatic test_mask();
    clear_reqs();
    set_req(0, 11'h123, 3'd1, 12'h456, 12'h789, 1'b1);
    en_mask_in = 4'b1110;
    req_on = 4'b0001;
    repeat (4) cycle();
    checks++;
    if (text_on !== 1'b1 || grant_idx !== 2'd0) begin
      errors++; $display("FAIL mask_no_tick: got on=%0b g=%0d expected on=1 g=0", text_on, grant_idx);
    end
    refresh_tick = 1'b1;
    cycle();
    refresh_tick = 1'b0;
    cycle(); cycle();
    checks++;
    if (text_on !== 1'b1) begin
      errors++; $display("FAIL mask_tick_cycle: got on=%0b expected 1", text_on);
    end
    cycle();
    checks++;
    if (text_on !== 1'b0 || text_rgb !== 12'h000) begin
      errors++; $display("FAIL mask_after_tick: got on=%0b rgb=%h expected on=0 rgb=000", text_on, text_rgb);
    end
    repeat (3) cycle();
    en_mask_in = '1;
    req_on = '0;
    refresh_tick = 1'b1;
    cycle();
    refresh_tick = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_back_to_back();
    logic [11:0] col [12];
    clear_reqs();
    mem[11'h010] = 8'hFF;
    mem[11'h020] = 8'hFF;
    set_req(0, 11'h010, 3'd2, 12'h000, 12'h000, 1'b0);
    set_req(2, 11'h020, 3'd5, 12'h000, 12'h000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      col[i] = 12'(i * 17 + 1);
      req_on = (i % 2 == 0) ? 4'b0001 : 4'b0100;
      if (i % 2 == 0) req_fg_rgb[11:0] = col[i];
      else            req_fg_rgb[35:24] = col[i];
      cycle();
      if (i >= 2) begin
        checks++;
        if (text_on !== 1'b1 || text_rgb !== col[i-2] ||
            grant_idx !== (((i - 2) % 2 == 0) ? 2'd0 : 2'd2)) begin
          errors++;
          $display("FAIL b2b[%0d]: got on=%0b rgb=%h g=%0d expected on=1 rgb=%h g=%0d", i,
                   text_on, text_rgb, grant_idx, col[i-2], ((i - 2) % 2 == 0) ? 0 : 2);
        end
      end
    end
    req_on = '0;
    repeat (3) cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_on       = N'($urandom);
      req_rom_addr = {$urandom, $urandom};
      req_bit_addr = 12'($urandom);
      req_fg_rgb   = {$urandom, $urandom};
      req_bg_rgb   = {$urandom, $urandom};
      req_solid    = N'($urandom);
      en_mask_in   = N'($urandom);
      refresh_tick = ($urandom_range(0, 15) == 0);
      cycle();
    end
    clear_reqs();
    en_mask_in = '1;
    refresh_tick = 1'b1;
    cycle();
    refresh_tick = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic test_conflict();
    clear_reqs();
    en_mask_in = '1;
    refresh_tick = 1'b1;
    cycle();
    refresh_tick = 1'b0;
    req_on = 4'b0011;
    repeat (37) cycle();
    req_on = '0;
    refresh_tick = 1'b1;
    cycle();
    refresh_tick = 1'b0;
    checks++;
`ifdef FONT_ARB_CONFLICT_CNT_EN
    if (conflict_cnt !== 16'd37) begin
      errors++; $display("FAIL conflict_37: got %0d expected 37", conflict_cnt);
    end
    req_on = 4'b1010;
    repeat (70000) cycle();
    req_on = '0;
    refresh_tick = 1'b1;
    cycle();
    refresh_tick = 1'b0;
    checks++;
    if (conflict_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL conflict_sat: got %h expected ffff", conflict_cnt);
    end
`else
    if (conflict_cnt !== 16'h0000) begin
      errors++; $display("FAIL conflict_off: got %0d expected 0", conflict_cnt);
    end
`endif
    repeat (3) cycle();
  endtask

  task automatic test_reset_midflight();
    clear_reqs();
    set_req(3, 11'h7FF, 3'd7, 12'hF00, 12'h0F0, 1'b1);
    req_on = 4'b1000;
    cycle(); cycle();
    reset = 1'b0;
    #2;
    checks++;
    if ({text_on, text_rgb, grant_idx, rom_addr} !== '0) begin
      errors++;
      $display("FAIL midflight_reset: got on=%0b rgb=%h g=%0d addr=%h expected all zero",
               text_on, text_rgb, grant_idx, rom_addr);
    end
    @(posedge clk); #1;
    clear_reqs();
    model_reset();
    reset = 1'b1;
    repeat (5) cycle();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single();
    test_solid();
    test_mask();
    test_back_to_back();
    test_random();
    test_conflict();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
